// File: rtl/hilo_pkg.sv
// Shared encodings, FSM states and helpers for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_t;

  localparam int unsigned DIV_ITERS   = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned 32/32 restoring divider, one quotient bit per step; 32 steps after load.
module iter_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // The dividend is shifted out of the quotient register as quotient bits shift in.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// E-stage HI/LO multiply/divide sequencer owning the HI/LO registers.
// Optional HILO_DIV_ZERO_FAST_EN: divide-by-zero completes on the issue edge without going busy.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_e,
  input  logic [1:0]  op_e,
  input  logic [31:0] rs_val_e,
  input  logic [31:0] rt_val_e,
  input  logic        hilo_read_e,
  input  logic        hi_write_e,
  input  logic        lo_write_e,
  input  logic [31:0] mt_data_e,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [4:0] MUL_LAST = 5'(MULT_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        div_load;
  logic        div_step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        issue_signed;
  logic        op_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign issue_signed = (op_e == OP_DIV);
  assign op_signed    = (op_q == OP_MULT) || (op_q == OP_DIV);

  iter_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs32(rs_val_e, issue_signed)),
    .divisor   (abs32(rt_val_e, issue_signed)),
    .quotient  (quo),
    .remainder (rem)
  );

  // Low 64 bits of a 64x64 product of sign-extended operands give the signed result.
  always_comb begin
    a_ext = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = a_ext * b_ext;
  end

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    quo_fix = (op_signed && (a_q[31] ^ b_q[31])) ? (~quo + 32'd1) : quo;
    rem_fix = (op_signed && a_q[31]) ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_e && !flush) begin
          op_d = op_t'(op_e);
          a_d  = rs_val_e;
          b_d  = rt_val_e;
          if (op_e[1]) begin
`ifdef HILO_DIV_ZERO_FAST_EN
            if (rt_val_e == 32'd0) begin
              hi_d   = rs_val_e;
              lo_d   = DIV_ZERO_LO;
              done_d = 1'b1;
            end else begin
              state_d  = DIV;
              cnt_d    = DIV_LAST;
              div_load = 1'b1;
            end
`else
            state_d  = DIV;
            cnt_d    = DIV_LAST;
            div_load = 1'b1;
`endif
          end else begin
            state_d = MUL;
            cnt_d   = MUL_LAST;
          end
        end else if (!flush) begin
          // A start in the same cycle takes priority and drops the MT write.
          if (hi_write_e) hi_d = mt_data_e;
          if (lo_write_e) lo_d = mt_data_e;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = IDLE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == 5'd0) state_d = FIX;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = DIV_ZERO_LO;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = busy & (start_e | hilo_read_e | hi_write_e | lo_write_e);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl (MULT_LATENCY=4).
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_e = 1'b0;
  logic [1:0]  op_e = 2'b00;
  logic [31:0] rs_val_e = '0;
  logic [31:0] rt_val_e = '0;
  logic        hilo_read_e = 1'b0;
  logic        hi_write_e = 1'b0;
  logic        lo_write_e = 1'b0;
  logic [31:0] mt_data_e = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HILO_DIV_ZERO_FAST_EN
  localparam int DZ_CYCLES = 0;
`else
  localparam int DZ_CYCLES = 33;
`endif

  hilo_muldiv_ctrl #(.MULT_LATENCY(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_e     (start_e),
    .op_e        (op_e),
    .rs_val_e    (rs_val_e),
    .rt_val_e    (rt_val_e),
    .hilo_read_e (hilo_read_e),
    .hi_write_e  (hi_write_e),
    .lo_write_e  (lo_write_e),
    .mt_data_e   (mt_data_e),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and run until busy drops; reports busy length and done at the drop.
  task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int cycles, output logic done_at_drop);
    op_e = op; rs_val_e = rs; rt_val_e = rt; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    done_at_drop = done;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, stall, hi_out, lo_out} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b stall=%b hi=%h lo=%h required all 0",
               busy, done, stall, hi_out, lo_out);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int c; logic d;
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, c, d);
    n_checks++;
    if (c !== 4 || d !== 1'b1) begin
      n_fail++; $display("FAIL mult_timing: got cycles=%0d done=%b required 4 1", c, d);
    end
    n_checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_signed: got %h_%h required ffffffff_fffffffa", hi_out, lo_out);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_single_pulse: got %b required 0", done);
    end
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, d);
    n_checks++;
    if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001 || c !== 4) begin
      n_fail++;
      $display("FAIL multu: got %h_%h cycles=%0d required fffffffe_00000001 4", hi_out, lo_out, c);
    end
  endtask

  task automatic test_div();
    int c; logic d;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, c, d);
    n_checks++;
    if (c !== 33 || d !== 1'b1) begin
      n_fail++; $display("FAIL div_timing: got cycles=%0d done=%b required 33 1", c, d);
    end
    n_checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_neg7_2: got hi=%h lo=%h required ffffffff fffffffd", hi_out, lo_out);
    end
    do_op(OP_DIVU, 32'd100, 32'd7, c, d);
    n_checks++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14) begin
      n_fail++; $display("FAIL divu_100_7: got hi=%h lo=%h required 2 e", hi_out, lo_out);
    end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, c, d);
    n_checks++;
    if (hi_out !== 32'd1 || lo_out !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_7_neg2: got hi=%h lo=%h required 1 fffffffd", hi_out, lo_out);
    end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, d);
    n_checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h required 0 80000000", hi_out, lo_out);
    end
  endtask

  task automatic test_div_zero();
    int c; logic d;
    do_op(OP_DIVU, 32'h0000_1234, 32'd0, c, d);
    n_checks++;
    if (c !== DZ_CYCLES || d !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_zero_timing: got cycles=%0d done=%b required %0d 1", c, d, DZ_CYCLES);
    end
    n_checks++;
    if (hi_out !== 32'h0000_1234 || lo_out !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL divu_zero: got hi=%h lo=%h required 1234 ffffffff", hi_out, lo_out);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL div_zero_done_pulse: got %b required 0", done);
    end
    do_op(OP_DIV, 32'hFFFF_FFEC, 32'd0, c, d);
    n_checks++;
    if (hi_out !== 32'hFFFF_FFEC || lo_out !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_neg_zero: got hi=%h lo=%h required ffffffec ffffffff", hi_out, lo_out);
    end
  endtask

  task automatic test_stall_read();
    int c; int bad;
    op_e = OP_DIVU; rs_val_e = 32'd100; rt_val_e = 32'd7; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    c = 0; bad = 0;
    while (busy && c < 100) begin
      if (c >= 4) hilo_read_e = 1'b1;
      #1;
      if (stall !== (c >= 4)) bad++;
      c++;
      tick();
    end
    #1;
    n_checks++;
    if (bad !== 0 || c !== 33) begin
      n_fail++; $display("FAIL stall_while_busy: got bad=%0d cycles=%0d required 0 33", bad, c);
    end
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b1 || hi_out !== 32'd2) begin
      n_fail++;
      $display("FAIL mfhi_release: got stall=%b done=%b hi=%h required 0 1 2", stall, done, hi_out);
    end
    hilo_read_e = 1'b0;
    tick();
  endtask

  task automatic test_mt();
    lo_write_e = 1'b1; mt_data_e = 32'hCAFE_F00D;
    tick();
    lo_write_e = 1'b0;
    n_checks++;
    if (lo_out !== 32'hCAFE_F00D || hi_out !== 32'd2) begin
      n_fail++; $display("FAIL mtlo: got hi=%h lo=%h required 2 cafef00d", hi_out, lo_out);
    end
    hi_write_e = 1'b1; lo_write_e = 1'b1; mt_data_e = 32'h1234_5678;
    tick();
    n_checks++;
    if (hi_out !== 32'h1234_5678 || lo_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mt_both: got hi=%h lo=%h required 12345678 x2", hi_out, lo_out);
    end
    lo_write_e = 1'b0; flush = 1'b1; mt_data_e = 32'hDEAD_BEEF;
    tick();
    hi_write_e = 1'b0; flush = 1'b0;
    n_checks++;
    if (hi_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mt_flushed: got hi=%h required 12345678", hi_out);
    end
  endtask

  task automatic test_flush();
    int bad;
    lo_write_e = 1'b1; mt_data_e = 32'hCAFE_F00D;
    tick();
    lo_write_e = 1'b0;
    op_e = OP_MULTU; rs_val_e = 32'd3; rt_val_e = 32'd5; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lo_out !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL flush_busy: got busy=%b done=%b lo=%h required 0 0 cafef00d", busy, done, lo_out);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || lo_out !== 32'hCAFE_F00D) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL flush_no_done: got %0d bad cycles required 0", bad);
    end
    op_e = OP_MULT; start_e = 1'b1; flush = 1'b1;
    tick();
    start_e = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_start_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int c; logic d;
    op_e = OP_MULTU; rs_val_e = 32'd3; rt_val_e = 32'd5; start_e = 1'b1;
    lo_write_e = 1'b1; mt_data_e = 32'h5555_5555;
    tick();
    lo_write_e = 1'b0;
    op_e = OP_DIV; rs_val_e = 32'd9; rt_val_e = 32'd3;
    #1;
    n_checks++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_on_start: got stall=%b busy=%b required 1 1", stall, busy);
    end
    c = 0;
    while (busy && c < 100) begin
      c++;
      tick();
      start_e = 1'b0;
    end
    n_checks++;
    if (c !== 4 || done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd15) begin
      n_fail++;
      $display("FAIL start_wins_busy_start_ignored: got cycles=%0d done=%b hi=%h lo=%h required 4 1 0 f",
               c, done, hi_out, lo_out);
    end
    do_op(OP_DIVU, 32'd9, 32'd3, c, d);
    n_checks++;
    if (c !== 33 || d !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd3) begin
      n_fail++;
      $display("FAIL issue_in_done_cycle: got cycles=%0d done=%b hi=%h lo=%h required 33 1 0 3",
               c, d, hi_out, lo_out);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    hi_write_e = 1'b1; mt_data_e = 32'hA5A5_A5A5;
    tick();
    hi_write_e = 1'b0;
    op_e = OP_DIV; rs_val_e = 32'd1000; rt_val_e = 32'd3; start_e = 1'b1;
    tick();
    start_e = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_mid: got busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
               busy, done, hi_out, lo_out);
    end
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || lo_out !== 32'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_aborts_op: got %0d bad cycles required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall_read();
    test_mt();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
